iter_alu: RTL

- Parametrised multi-cycle successor to the 4-bit combinational ALU: WIDTH-bit operands, 3-bit opcode and 8 operations.
- Shifts are iterative (one bit position per cycle); add/sub/logic/compare complete in one cycle.
- Valid/ready handshake on input and output, so the block can sit between a decode stage and a writeback/result register.

---
 rtl/iter_alu_pkg.sv | 27 ++
 rtl/iter_alu_if.sv | 39 +++
 rtl/iter_alu_comb.sv | 53 +++++
 rtl/iter_alu.sv | 127 ++++++++++++
 4 files changed

// File: rtl/iter_alu_pkg.sv
// alu_pkg: shared definitions for the iterative ALU.
//   - OP_* opcode encodings (3-bit, fully populated)
//   - state_t FSM state encoding (ST_IDLE / ST_SHIFT / ST_DONE)
//   - is_shift(): true for the opcodes executed by the iterative shifter
// Optional feature macro used elsewhere in this slice: ITER_ALU_OVF_EN.
package alu_pkg;

  localparam logic [2:0] OP_SRA = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SRA) || (op == OP_SRL) || (op == OP_SLL);
  endfunction

endpackage

// File: rtl/iter_alu_if.sv
// iter_alu_if: operand/result handshake bundle for iter_alu.
//   master (upstream/consumer side): drives in_valid, inA, inB, inC, op,
//     out_ready; observes in_ready, out_valid, ans, busy (and ovf).
//   slave  (iter_alu side): the mirror image.
// With ITER_ALU_OVF_EN defined the bundle also carries ovf.
interface iter_alu_if #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic [SHW-1:0]   inC;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ans;
  logic             busy;
`ifdef ITER_ALU_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, inA, inB, inC, op, out_ready,
`ifdef ITER_ALU_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, ans, busy
  );

  modport slave (
    input  in_valid, inA, inB, inC, op, out_ready,
`ifdef ITER_ALU_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, ans, busy
  );
endinterface

// File: rtl/iter_alu_comb.sv
// alu_comb: single-cycle combinational datapath of iter_alu.
//   a, b : operands (WIDTH bits)
//   op   : 3-bit opcode
//   res  : ADD/SUB (wrapping), AND, OR, SLT (signed); for shift opcodes it
//          passes a through, which is the result of a zero-distance shift.
//   ovf  : (ITER_ALU_OVF_EN only) signed overflow of ADD/SUB, else 0.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
`ifdef ITER_ALU_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] res
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt;

  always_comb begin
    sum  = a + b;
    diff = a - b;
    lt   = $signed(a) < $signed(b);
    res  = a;
    unique case (op)
      OP_ADD:  res = sum;
      OP_SUB:  res = diff;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, lt};
      default: res = a;
    endcase
  end

`ifdef ITER_ALU_OVF_EN
  always_comb begin
    ovf = 1'b0;
    unique case (op)
      // Same-sign operands yielding an opposite-sign sum.
      OP_ADD:  ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      // Opposite-sign operands yielding a difference whose sign differs from a.
      OP_SUB:  ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      default: ovf = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/iter_alu.sv
// iter_alu: multi-cycle ALU with valid/ready handshakes.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears all state
//   bus   : iter_alu_if.slave -- in_valid/in_ready/inA/inB/inC/op in,
//           out_valid/out_ready/ans out, busy high while shifting.
// Single-cycle ops (and shifts by 0) finish in one cycle; shifts by n>0
// take n cycles, one bit per cycle. ITER_ALU_OVF_EN adds a registered ovf
// flag (signed ADD/SUB overflow) that travels with ans.
module iter_alu
  import alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      reset,
  iter_alu_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [SHW-1:0]   cnt_q,   cnt_d;
  logic [2:0]       sop_q,   sop_d;
  logic [WIDTH-1:0] ans_q,   ans_d;
  logic             ovf_q,   ovf_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] comb_res;
  logic             comb_ovf;
  logic [WIDTH-1:0] acc_step;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a   (bus.inA),
    .b   (bus.inB),
    .op  (bus.op),
`ifdef ITER_ALU_OVF_EN
    .ovf (comb_ovf),
`endif
    .res (comb_res)
  );

`ifndef ITER_ALU_OVF_EN
  assign comb_ovf = 1'b0;
`endif

  // DONE with out_ready lets a new bundle in on the handoff edge.
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // One-bit shift of the accumulator for the captured shift opcode.
  always_comb begin
    acc_step = {1'b0, acc_q[WIDTH-1:1]};
    unique case (sop_q)
      OP_SRA:  acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      OP_SLL:  acc_step = {acc_q[WIDTH-2:0], 1'b0};
      default: acc_step = {1'b0, acc_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sop_d   = sop_q;
    ans_d   = ans_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_SHIFT: begin
        acc_d = acc_step;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          ans_d   = acc_step;
          ovf_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      default: begin
        if (accept) begin
          if (is_shift(bus.op) && (bus.inC != '0)) begin
            acc_d   = bus.inA;
            cnt_d   = bus.inC;
            sop_d   = bus.op;
            state_d = ST_SHIFT;
          end else begin
            // comb_res already equals inA for a zero-distance shift.
            ans_d   = comb_res;
            ovf_d   = comb_ovf;
            state_d = ST_DONE;
          end
        end else if ((state_q == ST_DONE) && bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sop_q   <= '0;
      ans_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sop_q   <= sop_d;
      ans_q   <= ans_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_SHIFT);
  assign bus.ans       = ans_q;
`ifdef ITER_ALU_OVF_EN
  assign bus.ovf       = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q ^ comb_ovf;
`endif

endmodule
